// File: rtl/rc5_defs_pkg.sv
// Shared RC5-32/12 definitions for the key expander, decryptor and encryptor.
// Holds word/round geometry, the S-table address width and the rotate helper.
package rc5_defs_pkg;

    localparam int W        = 32;
    localparam int R        = 12;
    localparam int T        = 2 * (R + 1);
    localparam int T_LENGTH = $clog2(T);
    localparam int LGW      = $clog2(W);
    // Round index is the S address without its low bit, so 2i and 2i-1 are simple concatenations.
    localparam int I_WIDTH  = T_LENGTH - 1;

    localparam logic [T_LENGTH-1:0] S_ADDR_TOP = T_LENGTH'(2 * R + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HB,
        ST_HA,
        ST_POST_B,
        ST_POST_A,
        ST_DONE
    } state_t;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] n);
        logic [2*W-1:0] dbl;
        dbl = {x, x} >> n;
        return dbl[W-1:0];
    endfunction

endpackage

// File: rtl/rc5_dec_half.sv
// One RC5 decryption half-round: rotr(x - s, y) ^ y.
// Latency: combinational. Backpressure: none.
module rc5_dec_half
    import rc5_defs_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] s,
    input  logic [W-1:0] y,
    output logic [W-1:0] z
);

    assign z = rotr(x - s, y[LGW-1:0]) ^ y;

endmodule

// File: rtl/rc5_decryptor.sv
// Iterative RC5-32/12 block decryptor, one half-round per clock from a registered-read S RAM.
// Latency: accept edge k -> out_valid seen high at edge k+2R+3. Backpressure: holds pt in DONE until out_ready.
module rc5_decryptor
    import rc5_defs_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*W-1:0]      ct,
    output logic [T_LENGTH-1:0] s_addr,
    input  logic [W-1:0]        s_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*W-1:0]      pt
);

    state_t              state_q, state_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [I_WIDTH-1:0]  i_q, i_d;
    logic [I_WIDTH-1:0]  i_dec;
    logic [T_LENGTH-1:0] s_addr_q, s_addr_d;
    logic                out_valid_q, out_valid_d;
    logic [2*W-1:0]      pt_q, pt_d;
    logic [W-1:0]        half_x, half_y, half_z;

    rc5_dec_half u_half (
        .x (half_x),
        .s (s_rdata),
        .y (half_y),
        .z (half_z)
    );

    assign in_ready  = (state_q == ST_IDLE) && key_valid;
    assign s_addr    = s_addr_q;
    assign out_valid = out_valid_q;
    assign pt        = pt_q;
    assign i_dec     = i_q - 1'b1;

    // s_addr_q always holds the address the current state's successor needs one cycle later.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        i_d         = i_q;
        s_addr_d    = s_addr_q;
        out_valid_d = out_valid_q;
        pt_d        = pt_q;
        half_x      = (state_q == ST_HA) ? a_q : b_q;
        half_y      = (state_q == ST_HA) ? b_q : a_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d      = ct[W-1:0];
                    b_d      = ct[2*W-1:W];
                    i_d      = I_WIDTH'(R);
                    s_addr_d = {I_WIDTH'(R), 1'b0};
                    state_d  = ST_HB;
                end
            end
            ST_HB: begin
                b_d      = half_z;
                s_addr_d = {i_dec, 1'b1};
                state_d  = ST_HA;
            end
            ST_HA: begin
                a_d = half_z;
                if (i_q > I_WIDTH'(1)) begin
                    i_d      = i_dec;
                    s_addr_d = {i_dec, 1'b0};
                    state_d  = ST_HB;
                end else begin
                    s_addr_d = '0;
                    state_d  = ST_POST_B;
                end
            end
            ST_POST_B: begin
                b_d     = b_q - s_rdata;
                state_d = ST_POST_A;
            end
            ST_POST_A: begin
                a_d         = a_q - s_rdata;
                pt_d        = {b_q, a_q - s_rdata};
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    s_addr_d    = S_ADDR_TOP;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            i_q         <= I_WIDTH'(R);
            s_addr_q    <= S_ADDR_TOP;
            out_valid_q <= 1'b0;
            pt_q        <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            i_q         <= i_d;
            s_addr_q    <= s_addr_d;
            out_valid_q <= out_valid_d;
            pt_q        <= pt_d;
        end
    end

endmodule

// File: tb/tb_rc5_decryptor.sv
// Bench for rc5_decryptor: S RAM model, software RC5 key schedule / encrypt / decrypt,
// randomized round trips plus handshake, reset and address-sequence checks.
module tb_rc5_decryptor;

    localparam int R = 12;
    localparam int T = 2 * (R + 1);
    localparam logic [31:0] PW = 32'hB7E15163;
    localparam logic [31:0] QW = 32'h9E3779B9;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ct;
    logic [4:0]  s_addr;
    logic [31:0] s_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] pt;

    logic [31:0] s_mem [0:T-1];
    logic [7:0]  key_b [0:15];
    int          errors = 0;
    int          checks = 0;

    rc5_decryptor dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .s_addr    (s_addr),
        .s_rdata   (s_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt)
    );

    always #5 clk = ~clk;

    // Synchronous-read S RAM
    always @(posedge clk) s_rdata <= s_mem[s_addr];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [31:0] n);
        int k;
        k = int'(n % 32);
        return (k == 0) ? x : ((x << k) | (x >> (32 - k)));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [31:0] n);
        return rotl(x, 32'd32 - (n % 32));
    endfunction

    task automatic expand_key();
        logic [31:0] l [0:3];
        logic [31:0] a, b;
        int ii, jj;
        for (int k = 0; k < 4; k++) l[k] = 32'h0;
        for (int k = 15; k >= 0; k--) l[k/4] = (l[k/4] << 8) + {24'h0, key_b[k]};
        s_mem[0] = PW;
        for (int k = 1; k < T; k++) s_mem[k] = s_mem[k-1] + QW;
        a = 0; b = 0; ii = 0; jj = 0;
        for (int k = 0; k < 3 * T; k++) begin
            a = rotl(s_mem[ii] + a + b, 32'd3);
            s_mem[ii] = a;
            b = rotl(l[jj] + a + b, a + b);
            l[jj] = b;
            ii = (ii + 1) % T;
            jj = (jj + 1) % 4;
        end
    endtask

    task automatic random_key();
        for (int k = 0; k < 16; k++) key_b[k] = 8'($urandom);
        expand_key();
    endtask

    function automatic logic [63:0] enc(input logic [63:0] p);
        logic [31:0] a, b;
        a = p[31:0] + s_mem[0];
        b = p[63:32] + s_mem[1];
        for (int r = 1; r <= R; r++) begin
            a = rotl(a ^ b, b) + s_mem[2*r];
            b = rotl(b ^ a, a) + s_mem[2*r+1];
        end
        return {b, a};
    endfunction

    function automatic logic [63:0] ref_dec(input logic [63:0] c);
        logic [31:0] a, b;
        a = c[31:0];
        b = c[63:32];
        for (int r = R; r >= 1; r--) begin
            b = rotr(b - s_mem[2*r+1], a) ^ a;
            a = rotr(a - s_mem[2*r], b) ^ b;
        end
        b = b - s_mem[1];
        a = a - s_mem[0];
        return {b, a};
    endfunction

    // Leaves the bench at the falling edge right after the accepting edge.
    task automatic send(input logic [63:0] c);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        ct = c;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // m0 = edges already elapsed since the accepting edge; lat = edge at which the result is taken.
    task automatic wait_out(input int m0, output int lat);
        int m;
        m = m0;
        while (!out_valid && m < 100) begin
            @(negedge clk);
            m++;
        end
        if (!out_valid) check_eq("out_valid_timeout", 64'(out_valid), 64'd1);
        lat = m + 1;
    endtask

    task automatic take_out(input int stall, output logic [63:0] got);
        logic [63:0] held;
        held = pt;
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_pt_stable", pt, held);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        end
        got = pt;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("idle_in_ready", 64'(in_ready), 64'd1);
        check_eq("idle_out_valid", 64'(out_valid), 64'd0);
        check_eq("idle_s_addr", 64'(s_addr), 64'd25);
    endtask

    task automatic run_block(input logic [63:0] c, input int stall, input logic early,
                             output logic [63:0] got, output int lat);
        send(c);
        out_ready = early;
        wait_out(0, lat);
        take_out(stall, got);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got, p, c;
        int          lat;

        rst = 1'b1;
        key_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ct = 64'h0;
        for (int k = 0; k < 16; k++) key_b[k] = 8'h00;
        expand_key();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_pt", pt, 64'd0);
        check_eq("rst_s_addr", 64'(s_addr), 64'd25);
        check_eq("rst_in_ready_nokey", 64'(in_ready), 64'd0);
        rst = 1'b1;
        key_valid = 1'b1;
        #1 check_eq("idle_in_ready_key", 64'(in_ready), 64'd1);

        // Zero-key known-answer vector
        run_block({32'h6D8F4B15, 32'hEEDBA521}, 0, 1'b0, got, lat);
        check_eq("kat_pt", got, 64'h0);
        check_eq("kat_latency", 64'(lat), 64'd27);

        random_key();

        // key_valid gating: nothing accepted until the key is ready, then on that same edge
        p = {$urandom, $urandom};
        @(negedge clk);
        key_valid = 1'b0;
        in_valid = 1'b1;
        ct = enc(p);
        #1 check_eq("nokey_in_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("nokey_in_ready", 64'(in_ready), 64'd0);
            check_eq("nokey_no_accept", 64'(s_addr), 64'd25);
        end
        key_valid = 1'b1;
        #1 check_eq("key_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("key_accept_addr", 64'(s_addr), 64'd24);
        check_eq("key_busy_in_ready", 64'(in_ready), 64'd0);
        wait_out(0, lat);
        check_eq("key_latency", 64'(lat), 64'd27);
        take_out(0, got);
        check_eq("key_pt", got, p);

        // Output backpressure for 10 cycles
        p = {$urandom, $urandom};
        run_block(enc(p), 10, 1'b0, got, lat);
        check_eq("bp_pt", got, p);

        // Async reset in the HA half-round at i=5 drops the block in flight
        p = {$urandom, $urandom};
        send(enc(p));
        repeat (15) @(negedge clk);
        check_eq("ha_i5_addr", 64'(s_addr), 64'd9);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_s_addr", 64'(s_addr), 64'd25);
        check_eq("midrst_pt", pt, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        p = {$urandom, $urandom};
        run_block(enc(p), 0, 1'b0, got, lat);
        check_eq("postrst_pt", got, p);
        check_eq("postrst_latency", 64'(lat), 64'd27);

        // Rotate corners on the first B half-round, plus the S address walk
        for (int n = 0; n < 4; n++) begin
            c[63:32] = $urandom;
            c[31:0]  = ($urandom & 32'hFFFF_FFE0) | ((n % 2 == 0) ? 32'd0 : 32'd31);
            @(negedge clk);
            check_eq("pre_accept_addr", 64'(s_addr), 64'd25);
            send(c);
            for (int j = 0; j < 25; j++) begin
                check_eq("s_addr_seq", 64'(s_addr), (j < 24) ? 64'(24 - j) : 64'd0);
                @(negedge clk);
            end
            wait_out(25, lat);
            check_eq("corner_latency", 64'(lat), 64'd27);
            take_out(0, got);
            check_eq("corner_pt", got, ref_dec(c));
        end

        // Random round trips, key refreshed every 50 blocks, mixed output stalls
        for (int n = 0; n < 200; n++) begin
            int   stall;
            logic early;
            if (n % 50 == 0) random_key();
            p = {$urandom, $urandom};
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            early = (stall == 0) && ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_block(enc(p), stall, early, got, lat);
            check_eq("rt_pt", got, p);
            check_eq("rt_latency", 64'(lat), 64'd27);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
